mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM-stage) requester.
- Serialises accesses and drives a fixed-latency memory.
- Returns read data to the winning requester with a one-cycle ready pulse.
- Raises a pipeline stall while any request is outstanding, so the PC and pipeline registers can be frozen.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_lat_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_defs : shared FSM state encodings and grant-owner codes for the
//                unified-memory port arbiter.
// Rev 1.0
// ============================================================================
package mem_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam logic c_GNT_IF = 1'b0;
    localparam logic c_GNT_DM = 1'b1;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

endpackage : mem_arb_defs
`default_nettype wire

// File: rtl/mem_arb_lat_counter.sv
`default_nettype none
// ============================================================================
// mem_arb_lat_counter : memory-latency down-counter; loaded with MEM_LAT in
//                       the access cycle, flags the final WAIT cycle.
// Rev 1.0
// ============================================================================
module mem_arb_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_wait,
    output logic o_last
);

    localparam int c_CW = $clog2(MEM_LAT + 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_CW'(MEM_LAT);
        end else if (i_wait && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = i_wait && (r_cnt == c_CW'(1));

endmodule : mem_arb_lat_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : serialises IF and DM requests onto one fixed-latency
//                    single-port memory, with DM priority and IF anti-starvation.
// Optional: MEM_ARB_PERF_CNT_EN adds internal stall/grant performance counters.
// Rev 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [c_ADDR_W-1:0] if_addr,
    output logic                if_ready,
    output logic [c_DATA_W-1:0] if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [c_ADDR_W-1:0] dm_addr,
    input  logic [c_DATA_W-1:0] dm_wdata,
    output logic                dm_ready,
    output logic [c_DATA_W-1:0] dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [c_ADDR_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic [c_DATA_W-1:0] mem_rdata,
    output logic                stall
);

    localparam int c_SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_owner;
    logic                r_we;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_wdata;
    logic [c_DATA_W-1:0] r_if_rdata;
    logic [c_DATA_W-1:0] r_dm_rdata;
    logic [c_SW-1:0]     r_starve;
    logic                w_dm_win;
    logic                w_grant;
    logic                w_last;

    // DM has priority unless IF has already lost STARVE_LIMIT times in a row.
    assign w_dm_win = dm_req && !(if_req && (r_starve == c_STARVE_MAX));
    assign w_grant  = (r_state == ST_IDLE) && (if_req || dm_req);

    mem_arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clock),
        .rst    (reset),
        .i_load (r_state == ST_ACCESS),
        .i_wait (r_state == ST_WAIT),
        .o_last (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_ready    = 1'b0;
        dm_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if_ready    = (r_owner == c_GNT_IF);
                dm_ready    = (r_owner == c_GNT_DM);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction attributes are frozen at grant; requester inputs are ignored afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner  <= c_GNT_IF;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_dm_win) begin
                r_owner <= c_GNT_DM;
                r_we    <= dm_we;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                if (!if_req) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_owner  <= c_GNT_IF;
                r_we     <= 1'b0;
                r_addr   <= if_addr;
                r_wdata  <= '0;
                r_starve <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_last && !r_we) begin
            if (r_owner == c_GNT_IF) begin
                r_if_rdata <= mem_rdata;
            end else begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Drops in the ready cycle so the pipeline advances on that same edge.
    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_if_grants;
    logic [31:0] r_dm_grants;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_if_grants    <= '0;
            r_dm_grants    <= '0;
        end else begin
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_grant && !w_dm_win) begin
                r_if_grants <= r_if_grants + 32'd1;
            end
            if (w_grant && w_dm_win) begin
                r_dm_grants <= r_dm_grants + 32'd1;
            end
        end
    end
`else
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed + randomized bench with a transaction-level
//                       reference model of the memory port arbiter.
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT = 3;
    localparam int SL  = 4;
    localparam logic [31:0] MEMK = 32'h8C090000;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .MEM_LAT      (LAT),
        .STARVE_LIMIT (SL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: a transaction granted in cycle g strobes memory in g+1,
    // completes in g+LAT+2 and the arbiter is free again in g+LAT+3.
    int          g      = -1;
    int          nf     = 0;
    int          starve = 0;
    bit          t_dm, t_we;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] m_if_rd = 32'h0;
    logic [31:0] m_dm_rd = 32'h0;
    bit          rdy_if_q, rdy_dm_q, gnt_if, gnt_dm;
    int          resp_cyc = -1;
    logic [31:0] resp_val;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ MEMK;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit e_en, e_ifr, e_dmr, e_st, dm_win;
        if (g >= 0 && cyc == g + LAT + 2 && !t_we) begin
            if (t_dm) m_dm_rd = memf(t_addr);
            else      m_if_rd = memf(t_addr);
        end
        e_en  = (g >= 0) && (cyc == g + 1);
        e_ifr = (g >= 0) && (cyc == g + LAT + 2) && !t_dm;
        e_dmr = (g >= 0) && (cyc == g + LAT + 2) && t_dm;
        e_st  = (if_req && !e_ifr) || (dm_req && !e_dmr);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_en && t_we);
        if (e_en) begin
            chk("mem_addr", mem_addr, t_addr);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("if_ready", if_ready, e_ifr);
        chk("dm_ready", dm_ready, e_dmr);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("stall", stall, e_st);
        if (mem_en === 1'b1) begin
            resp_cyc = cyc + LAT;
            resp_val = memf(mem_addr);
        end
        rdy_if_q = e_ifr;
        rdy_dm_q = e_dmr;
        if (e_ifr) gnt_if = 1'b0;
        if (e_dmr) gnt_dm = 1'b0;
        if (reset) begin
            g = -1; nf = cyc + 1; starve = 0;
            m_if_rd = 32'h0; m_dm_rd = 32'h0;
            gnt_if = 1'b0; gnt_dm = 1'b0;
        end else if (cyc >= nf && (if_req || dm_req)) begin
            dm_win = dm_req && !(if_req && starve == SL);
            if (dm_win) starve = if_req ? ((starve < SL) ? starve + 1 : SL) : 0;
            else        starve = 0;
            g       = cyc;
            nf      = cyc + LAT + 3;
            t_dm    = dm_win;
            t_we    = dm_win && dm_we;
            t_addr  = dm_win ? dm_addr : if_addr;
            t_wdata = dm_wdata;
            if (dm_win) gnt_dm = 1'b1;
            else        gnt_if = 1'b1;
        end
        cyc++;
    endtask

    task automatic step_neg();
        @(negedge clock);
        if (chk_en) model_step();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        mem_rdata = (cyc == resp_cyc) ? resp_val : $urandom;
    endtask

    initial begin
        int dmc, ifs;
        bit adv, ifp, dmp;
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;

        // Reset held with a pending IF request.
        tick();
        chk_en = 1'b1;
        step_neg();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_dm_ready", dm_ready, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        tick();
        reset = 1'b0; if_req = 1'b0;
        step_neg();
        tick();

        // Single IF read.
        if_req = 1'b1; if_addr = 32'h4;
        for (int k = 0; k <= LAT + 2; k++) begin
            step_neg();
            chk("t1_mem_en", mem_en, k == 1);
            chk("t1_if_ready", if_ready, k == LAT + 2);
            chk("t1_stall", stall, k < LAT + 2);
            if (k == LAT + 2) chk("t1_if_rdata", if_rdata, 32'h8C090004);
            tick();
        end
        if_req = 1'b0;

        // Simultaneous IF and DM reads: DM first.
        if_req = 1'b1; if_addr = 32'h8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        for (int k = 0; k <= 2 * LAT + 5; k++) begin
            if (k == LAT + 3) dm_req = 1'b0;
            step_neg();
            chk("t2_mem_en", mem_en, (k == 1) || (k == LAT + 4));
            chk("t2_dm_ready", dm_ready, k == LAT + 2);
            chk("t2_if_ready", if_ready, k == 2 * LAT + 5);
            if (k == LAT + 2) chk("t2_dm_rdata", dm_rdata, 32'h8C090100);
            if (k == 2 * LAT + 5) chk("t2_if_rdata", if_rdata, 32'h8C090008);
            tick();
        end
        if_req = 1'b0;

        // DM write; requester changes its bus right after the grant.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
        for (int k = 0; k <= LAT + 2; k++) begin
            if (k == 1) begin dm_addr = 32'h24; dm_wdata = 32'h0; end
            step_neg();
            chk("t3_mem_we", mem_we, k == 1);
            if (k == 1) begin
                chk("t3_mem_addr", mem_addr, 32'h20);
                chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
            end
            chk("t3_dm_ready", dm_ready, k == LAT + 2);
            chk("t3_dm_rdata", dm_rdata, 32'h8C090100);
            tick();
        end
        dm_req = 1'b0; dm_we = 1'b0;

        // Starvation: both held, IF must win after every SL DM completions.
        dmc = 0; ifs = 0; adv = 1'b0;
        if_req = 1'b1; if_addr = 32'hC; dm_req = 1'b1; dm_addr = 32'h200;
        for (int n = 0; n < 200 && ifs < 2; n++) begin
            if (adv) dm_addr = dm_addr + 32'h4;
            adv = 1'b0;
            step_neg();
            if (dm_ready) begin dmc++; adv = 1'b1; end
            if (if_ready) begin
                chk("t4_dm_before_if", dmc, SL);
                dmc = 0;
                ifs++;
            end
            tick();
        end
        chk("t4_if_grants", ifs, 2);
        if_req = 1'b0; dm_req = 1'b0;

        // Reset in mid-WAIT drops the transaction; the held request is re-served.
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 0; k <= LAT + 6; k++) begin
            reset = (k == 3);
            step_neg();
            chk("t5_mem_en", mem_en, (k == 1) || (k == 5));
            chk("t5_if_ready", if_ready, k == LAT + 6);
            if (k == 4) chk("t5_if_rdata_clr", if_rdata, 32'h0);
            if (k == LAT + 6) chk("t5_if_rdata", if_rdata, 32'h8C090040);
            tick();
        end
        reset = 1'b0; if_req = 1'b0;

        // Randomized traffic with occasional resets.
        ifp = 1'b0; dmp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (rdy_if_q) ifp = 1'b0;
            if (rdy_dm_q) dmp = 1'b0;
            if (!ifp && $urandom_range(0, 2) == 0) begin
                ifp = 1'b1;
                if_addr = $urandom;
            end else if (gnt_if) begin
                if_addr = $urandom;
            end
            if (!dmp && $urandom_range(0, 2) == 0) begin
                dmp = 1'b1;
                dm_addr = $urandom;
                dm_wdata = $urandom;
                dm_we = 1'($urandom_range(0, 1));
            end else if (gnt_dm) begin
                dm_addr = $urandom;
                dm_wdata = $urandom;
                dm_we = 1'($urandom_range(0, 1));
            end
            if_req = ifp;
            dm_req = dmp;
            reset = ($urandom_range(0, 199) == 0);
            step_neg();
            tick();
        end
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step_neg();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
